// File: rtl/aes_key_ctx_mem_if.sv
// Bus between key-load control / round datapath (master) and the key context memory (slave).
// The external S-box lives on the master side, so new_sboxw is a master output.
interface aes_key_ctx_mem_if #(
  parameter int unsigned NUM_CTX = 4,
  parameter int unsigned CTX_W   = 2
);
  logic [255:0]       key;
  logic [3:0]         keylen;
  logic               init;
  logic [CTX_W-1:0]   init_ctx;
  logic               invalidate;
  logic [CTX_W-1:0]   inval_ctx;
  logic               ready;
  logic               error;
  logic [NUM_CTX-1:0] ctx_valid;
  logic [CTX_W-1:0]   round_ctx;
  logic [3:0]         round_number;
  logic [127:0]       round_key;
  logic [31:0]        sboxw;
  logic [31:0]        new_sboxw;

  modport master (
    output key, keylen, init, init_ctx, invalidate, inval_ctx,
    output round_ctx, round_number, new_sboxw,
    input  ready, error, ctx_valid, round_key, sboxw
  );

  modport slave (
    input  key, keylen, init, init_ctx, invalidate, inval_ctx,
    input  round_ctx, round_number, new_sboxw,
    output ready, error, ctx_valid, round_key, sboxw
  );
endinterface

// File: rtl/aes_key_ctx_mem.sv
// Multi-context AES-128/192/256 key schedule store; expands one word per cycle via a shared S-box.
// Optional macro AES_KEY_CTX_ZEROIZE_EN wipes stored words on reset, init and invalidate.
module aes_key_ctx_mem #(
  parameter int unsigned NUM_CTX = 4,
  parameter int unsigned CTX_W   = 2
) (
  input  logic             clk,
  input  logic             reset,
  aes_key_ctx_mem_if.slave bus
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned NWORDS = 60;
  localparam int unsigned IDX_W  = 6;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GEN, S_DONE} state_e;

  state_e             state_q;
  logic               ready_q;
  logic               error_q;
  logic [NUM_CTX-1:0] ctx_valid_q;
  logic [WORD_W-1:0]  sboxw_q;
  logic [WORD_W-1:0]  prev_q;
  logic [CTX_W-1:0]   ctx_q;
  logic [1:0]         kl_q;
  logic [IDX_W-1:0]   i_q;
  logic [2:0]         mod_q;
  logic [7:0]         rcon_q;
  logic [1:0]         ctx_kl_q [NUM_CTX];
  logic [WORD_W-1:0]  mem_q [NUM_CTX][NWORDS];
  logic [127:0]       round_key_q;

  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic init_ok_c;
  logic accept_c;
  logic inval_ok_c;

  always_comb begin
    init_ok_c  = (bus.keylen < 4'd3) && (32'(bus.init_ctx) < NUM_CTX);
    accept_c   = (state_q == S_IDLE) && bus.init && init_ok_c;
    // The context under expansion (LOAD..DONE) is protected from invalidation.
    inval_ok_c = bus.invalidate && (32'(bus.inval_ctx) < NUM_CTX) &&
                 !((state_q != S_IDLE) && (bus.inval_ctx == ctx_q));
  end

  logic [IDX_W-1:0]  nk_c;
  logic [IDX_W-1:0]  last_c;
  logic [IDX_W-1:0]  back_idx_c;
  logic [2:0]        mod_next_c;
  logic              rcon_use_c;
  logic              sbox_use_c;
  logic [WORD_W-1:0] last_key_word_c;
  logic [WORD_W-1:0] t_c;
  logic [WORD_W-1:0] w_new_c;
  logic [WORD_W-1:0] sbox_next_c;

  // Word generator: w[i] = w[i-Nk] ^ t, and the S-box request for word i+1.
  always_comb begin
    nk_c            = 6'd4;
    last_c          = 6'd43;
    last_key_word_c = bus.key[159:128];
    case (kl_q)
      2'd1: begin
        nk_c            = 6'd6;
        last_c          = 6'd51;
        last_key_word_c = bus.key[95:64];
      end
      2'd2: begin
        nk_c            = 6'd8;
        last_c          = 6'd59;
        last_key_word_c = bus.key[31:0];
      end
      default: ;
    endcase
    back_idx_c = i_q - nk_c;
    rcon_use_c = (mod_q == 3'd0);
    sbox_use_c = rcon_use_c || ((kl_q == 2'd2) && (mod_q == 3'd4));
    t_c        = prev_q;
    if (rcon_use_c) begin
      t_c = bus.new_sboxw ^ {rcon_q, 24'h0};
    end else if (sbox_use_c) begin
      t_c = bus.new_sboxw;
    end
    w_new_c     = mem_q[ctx_q][back_idx_c] ^ t_c;
    mod_next_c  = (6'(mod_q) == (nk_c - 6'd1)) ? 3'd0 : (mod_q + 3'd1);
    sbox_next_c = '0;
    if (mod_next_c == 3'd0) begin
      sbox_next_c = rot_word(w_new_c);
    end else if ((kl_q == 2'd2) && (mod_next_c == 3'd4)) begin
      sbox_next_c = w_new_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      error_q     <= 1'b0;
      ctx_valid_q <= '0;
      sboxw_q     <= '0;
      prev_q      <= '0;
      ctx_q       <= '0;
      kl_q        <= '0;
      i_q         <= '0;
      mod_q       <= '0;
      rcon_q      <= 8'h01;
      for (int c = 0; c < NUM_CTX; c++) ctx_kl_q[c] <= '0;
    end else begin
      error_q <= 1'b0;
      if (inval_ok_c) ctx_valid_q[bus.inval_ctx] <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.init) begin
            if (init_ok_c) begin
              state_q                    <= S_LOAD;
              ready_q                    <= 1'b0;
              ctx_q                      <= bus.init_ctx;
              kl_q                       <= bus.keylen[1:0];
              ctx_kl_q[bus.init_ctx]     <= bus.keylen[1:0];
              ctx_valid_q[bus.init_ctx]  <= 1'b0;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          state_q <= S_GEN;
          i_q     <= nk_c;
          mod_q   <= 3'd0;
          rcon_q  <= 8'h01;
          prev_q  <= last_key_word_c;
          sboxw_q <= rot_word(last_key_word_c);
        end
        S_GEN: begin
          prev_q <= w_new_c;
          i_q    <= i_q + 6'd1;
          mod_q  <= mod_next_c;
          if (rcon_use_c) rcon_q <= xtime(rcon_q);
          if (i_q == last_c) begin
            state_q <= S_DONE;
            sboxw_q <= '0;
          end else begin
            sboxw_q <= sbox_next_c;
          end
        end
        S_DONE: begin
          state_q            <= S_IDLE;
          ready_q            <= 1'b1;
          ctx_valid_q[ctx_q] <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [NUM_CTX-1:0] zero_c;
`ifdef AES_KEY_CTX_ZEROIZE_EN
  always_comb begin
    zero_c = '0;
    for (int c = 0; c < NUM_CTX; c++) begin
      zero_c[c] = reset ||
                  (accept_c && (32'(bus.init_ctx) == 32'(c))) ||
                  (inval_ok_c && (32'(bus.inval_ctx) == 32'(c)));
    end
  end
`else
  assign zero_c = '0;
`endif

  // Schedule storage: key words in LOAD, one derived word per GEN cycle, zeroing wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == S_LOAD) begin
        for (int j = 0; j < 8; j++) begin
          if (6'(j) < nk_c) mem_q[ctx_q][j] <= bus.key[255 - 32*j -: 32];
        end
      end
      if (state_q == S_GEN) mem_q[ctx_q][i_q] <= w_new_c;
    end
    for (int c = 0; c < NUM_CTX; c++) begin
      if (zero_c[c]) begin
        for (int w = 0; w < NWORDS; w++) mem_q[c][w] <= '0;
      end
    end
  end

  logic             rd_ok_c;
  logic [3:0]       rd_nr_c;
  logic [3:0]       rd_round_c;
  logic [IDX_W-1:0] rd_base_c;

  always_comb begin
    rd_ok_c = 1'b0;
    rd_nr_c = 4'd10;
    if (32'(bus.round_ctx) < NUM_CTX) begin
      rd_nr_c = 4'd10 + {1'b0, ctx_kl_q[bus.round_ctx], 1'b0};
      rd_ok_c = ctx_valid_q[bus.round_ctx] && (bus.round_number <= rd_nr_c);
    end
    // Clamp keeps the word index inside the array; such reads are gated off anyway.
    rd_round_c = (bus.round_number > 4'd14) ? 4'd14 : bus.round_number;
    rd_base_c  = {rd_round_c, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      round_key_q <= '0;
    end else if (rd_ok_c) begin
      round_key_q <= {mem_q[bus.round_ctx][rd_base_c],
                      mem_q[bus.round_ctx][rd_base_c + 6'd1],
                      mem_q[bus.round_ctx][rd_base_c + 6'd2],
                      mem_q[bus.round_ctx][rd_base_c + 6'd3]};
    end else begin
      round_key_q <= '0;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.error     = error_q;
  assign bus.ctx_valid = ctx_valid_q;
  assign bus.sboxw     = sboxw_q;
  assign bus.round_key = round_key_q;
endmodule
